arb_rr4: RTL and testbench
==========================

ARB_RR4 -- requirements
Module: arb_rr4

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum consecutive grant cycles per owner; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req  input  4  request lines; bit k = requester k.
REQ-005 done  input  1  current owner releases the resource this cycle.
REQ-006 gnt  output  4  one-hot grant; drives shared-resource select, equivalent to 2-to-4 decoder outputs.
REQ-007 gnt_id  output  2  binary index of current owner; valid only while gnt_vld=1.
REQ-008 gnt_vld  output  1  decoder-enable equivalent; high iff gnt is non-zero.
REQ-009 tout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX expiry.
REQ-010 All outputs SHALL be registered; no combinational path from req or done to any output.

Function
REQ-011 States SHALL be IDLE, GRANT and GAP; encoding is free.
REQ-012 Rotating pointer ptr (2 bits) SHALL hold the highest-priority index; priority order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 IDLE, req==0: remain IDLE; gnt=0, gnt_vld=0.
REQ-014 IDLE, req!=0 at edge N: select first set bit in priority order; from edge N+1, gnt=one-hot(sel), gnt_id=sel, gnt_vld=1, state GRANT, hold counter cnt=1.
REQ-015 Grant latency SHALL be exactly one cycle from req sampled in IDLE to gnt asserted.
REQ-016 GRANT: gnt, gnt_id SHALL remain stable until release; requests from other requesters SHALL NOT preempt the owner.
REQ-017 Release conditions, sampled at an edge in GRANT: (a) done=1, (b) req[gnt_id]=0, (c) cnt==HOLD_MAX.
REQ-018 On release: next cycle gnt=0, gnt_vld=0, state GAP, ptr=gnt_id+1 mod 4 (wrap 3->0).
REQ-019 Otherwise in GRANT: cnt increments by 1; cnt width 4 bits, never exceeds HOLD_MAX.
REQ-020 tout SHALL pulse high for the single cycle following release only when (c) holds and neither (a) nor (b) holds; if several conditions coincide, done/req-drop take precedence and tout stays 0.
REQ-021 GAP SHALL last exactly one cycle with gnt=0 (bus turnaround), then go to IDLE; requests are not evaluated in GAP.
REQ-022 done SHALL be ignored in IDLE and GAP.
REQ-023 gnt SHALL never have more than one bit set; gnt_vld SHALL equal |gnt in every cycle.
REQ-024 A requester holding req continuously SHALL be granted within 3 other grant periods (starvation bound).
REQ-025 gnt_id SHALL retain its last value while gnt_vld=0.

Reset
REQ-026 rst=1 at an edge: state IDLE, ptr=0, cnt=0, gnt=0, gnt_id=0, gnt_vld=0, tout=0 from the next cycle, regardless of state.
REQ-027 Reset mid-grant SHALL drop gnt without GAP and without tout; rst has priority over all other inputs.
REQ-028 First arbitration after reset SHALL favour requester 0.

Verification
REQ-029 Reset, then req=4'b1111 held, done pulsed one cycle after each grant -> grants 0,1,2,3,0 in order, each followed by one GAP cycle with gnt=0.
REQ-030 req=4'b0100 held, done=0, HOLD_MAX=8 -> gnt=4'b0100 for exactly 8 cycles, tout=1 for one cycle, GAP, IDLE, then re-grant to 2 (ptr=3, no other requesters).
REQ-031 Owner 1 granted, req drops to 4'b1000 while req[1] falls -> release next cycle, tout=0, next grant=3.
REQ-032 Owner 3 released -> ptr wraps to 0; with req=4'b1010 next grant is 1.
REQ-033 rst asserted during GRANT with gnt=4'b0010 -> next cycle gnt=0, gnt_vld=0, tout=0, ptr=0; req=4'b1111 then grants 0.
REQ-034 Coincident done=1 and cnt==HOLD_MAX -> normal release, tout=0; assertion check of REQ-023 throughout all scenarios.

Source files
------------

// File: rtl/arb_rr4.sv
// ============================================================================
//  Module   : arb_rr4
//  Purpose  : Four-requester round-robin arbiter with a bounded hold time.
//             One owner holds the resource until it signals done, drops its
//             request, or reaches HOLD_MAX cycles. Every release is followed
//             by a single turnaround (GAP) cycle with no grant.
//  Ports    : clk      - clock, rising edge
//             rst      - synchronous active-high reset
//             req[3:0] - request lines, bit k = requester k
//             done     - current owner releases the resource
//             gnt[3:0] - one-hot grant (registered)
//             gnt_id   - binary index of owner, holds last value when idle
//             gnt_vld  - high iff gnt is non-zero
//             tout     - one-cycle pulse after a HOLD_MAX forced release
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_rr4 #(
   parameter int HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_vld,
   output logic       tout
);

   localparam logic [3:0] C_HOLD_MAX = 4'(HOLD_MAX);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] gnt_id_q, gnt_id_d;
   logic       gnt_vld_q, gnt_vld_d;
   logic       tout_q, tout_d;

   logic       sel_found;
   logic [1:0] sel_id;
   logic [1:0] cand;
   logic       rel_done;
   logic       rel_drop;
   logic       rel_max;

   // First set request scanning from ptr upwards, wrapping modulo 4.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = ptr_q;
      cand      = ptr_q;
      for (int i = 0; i < 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!sel_found && req[cand]) begin
            sel_found = 1'b1;
            sel_id    = cand;
         end
      end
   end

   always_comb begin
      rel_done = done;
      rel_drop = ~req[gnt_id_q];
      // >= guards against an out-of-range count ever sticking the grant
      rel_max  = (cnt_q >= C_HOLD_MAX);
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      gnt_vld_d = gnt_vld_q;
      tout_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            gnt_d     = 4'b0000;
            gnt_vld_d = 1'b0;
            if (sel_found) begin
               state_d   = ST_GRANT;
               gnt_d     = 4'b0001 << sel_id;
               gnt_id_d  = sel_id;
               gnt_vld_d = 1'b1;
               cnt_d     = 4'd1;
            end
         end

         ST_GRANT: begin
            if (rel_done || rel_drop || rel_max) begin
               state_d   = ST_GAP;
               gnt_d     = 4'b0000;
               gnt_vld_d = 1'b0;
               ptr_d     = gnt_id_q + 2'd1;
               cnt_d     = 4'd0;
               // Timeout is only reported when expiry alone forced the release
               tout_d    = rel_max && !rel_done && !rel_drop;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         ST_GAP: begin
            // Turnaround cycle: requests and done are not looked at here
            state_d   = ST_IDLE;
            gnt_d     = 4'b0000;
            gnt_vld_d = 1'b0;
         end

         default: begin
            state_d   = ST_IDLE;
            gnt_d     = 4'b0000;
            gnt_vld_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 2'd0;
         cnt_q     <= 4'd0;
         gnt_q     <= 4'b0000;
         gnt_id_q  <= 2'd0;
         gnt_vld_q <= 1'b0;
         tout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         gnt_vld_q <= gnt_vld_d;
         tout_q    <= tout_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign gnt_vld = gnt_vld_q;
   assign tout    = tout_q;

endmodule

`default_nettype wire

// File: tb/tb_arb_rr4.sv
// ============================================================================
//  Module   : tb_arb_rr4
//  Purpose  : Directed self-checking bench for arb_rr4 (HOLD_MAX = 8).
//             Inputs change 1 time unit after a rising edge; outputs are
//             checked at the same point, i.e. they reflect that edge.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arb_rr4;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_vld;
   logic       tout;

   int n_tests = 0;
   int n_fail  = 0;
   logic mon_en = 1'b0;

   arb_rr4 #(.HOLD_MAX(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_vld (gnt_vld),
      .tout    (tout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic t);
      check({tag, ".gnt"},     32'(gnt),     32'(g));
      check({tag, ".gnt_id"},  32'(gnt_id),  32'(id));
      check({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(|g));
      check({tag, ".tout"},    32'(tout),    32'(t));
   endtask

   // Grant is one-hot-or-zero and gnt_vld tracks it in every cycle
   always @(negedge clk) begin
      if (mon_en) begin
         check("onehot0", 32'($onehot0(gnt)), 32'd1);
         check("vld_eq",  32'(gnt_vld),       32'(|gnt));
      end
   end

   initial begin
      rst  = 1'b1;
      req  = 4'b0000;
      done = 1'b0;

      // Reset state
      step();
      expect_out("reset", 4'b0000, 2'd0, 1'b0);
      mon_en = 1'b1;

      // Idle with no requests; done is ignored in IDLE
      rst  = 1'b0;
      done = 1'b1;
      step();
      expect_out("idle0", 4'b0000, 2'd0, 1'b0);
      step();
      expect_out("idle1", 4'b0000, 2'd0, 1'b0);
      done = 1'b0;

      // Rotation 0,1,2,3,0 with done in the first grant cycle
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         expect_out($sformatf("rot%0d.grant", k), 4'b0001 << (k % 4), 2'(k % 4), 1'b0);
         done = 1'b1;
         step();
         expect_out($sformatf("rot%0d.gap", k), 4'b0000, 2'(k % 4), 1'b0);
         done = 1'b0;
         step();
         expect_out($sformatf("rot%0d.idle", k), 4'b0000, 2'(k % 4), 1'b0);
      end

      // HOLD_MAX expiry: exactly 8 grant cycles then tout pulse
      rst = 1'b1;
      req = 4'b0000;
      step();
      rst = 1'b0;
      req = 4'b0100;
      for (int i = 1; i <= 8; i++) begin
         step();
         expect_out($sformatf("hold.c%0d", i), 4'b0100, 2'd2, 1'b0);
      end
      step();
      expect_out("hold.tout", 4'b0000, 2'd2, 1'b1);
      step();
      expect_out("hold.idle", 4'b0000, 2'd2, 1'b0);
      step();
      expect_out("hold.regrant", 4'b0100, 2'd2, 1'b0);

      // Request drop releases without tout; ptr becomes 3
      req = 4'b0000;
      step();
      expect_out("drop.gap", 4'b0000, 2'd2, 1'b0);
      step();

      // ptr=3, only requester 1 -> grant 1
      req = 4'b0010;
      step();
      expect_out("r31.g1", 4'b0010, 2'd1, 1'b0);
      step();
      expect_out("r31.hold", 4'b0010, 2'd1, 1'b0);
      // Owner 1 drops while 3 raises -> release, no tout, then 3
      req = 4'b1000;
      step();
      expect_out("r31.rel", 4'b0000, 2'd1, 1'b0);
      step();
      expect_out("r31.idle", 4'b0000, 2'd1, 1'b0);
      step();
      expect_out("r31.g3", 4'b1000, 2'd3, 1'b0);

      // Owner 3 released by done, ptr wraps to 0, req=1010 -> grant 1
      req  = 4'b1010;
      done = 1'b1;
      step();
      expect_out("wrap.rel", 4'b0000, 2'd3, 1'b0);
      done = 1'b0;
      step();
      step();
      expect_out("wrap.g1", 4'b0010, 2'd1, 1'b0);
      // Requester 3 still asserting must not preempt owner 1
      step();
      expect_out("nopre.a", 4'b0010, 2'd1, 1'b0);
      step();
      expect_out("nopre.b", 4'b0010, 2'd1, 1'b0);

      // Reset mid-grant: immediate drop, no tout, ptr back to 0
      rst = 1'b1;
      step();
      expect_out("rstg.clr", 4'b0000, 2'd0, 1'b0);
      rst = 1'b0;
      req = 4'b1111;
      step();
      expect_out("rstg.g0", 4'b0001, 2'd0, 1'b0);

      // done coincident with cnt==HOLD_MAX: normal release, no tout
      for (int i = 2; i <= 8; i++) begin
         step();
         expect_out($sformatf("coin.c%0d", i), 4'b0001, 2'd0, 1'b0);
      end
      done = 1'b1;
      step();
      expect_out("coin.rel", 4'b0000, 2'd0, 1'b0);
      done = 1'b0;
      step();
      expect_out("coin.idle", 4'b0000, 2'd0, 1'b0);
      step();
      expect_out("coin.g1", 4'b0010, 2'd1, 1'b0);

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
